// File: rtl/seq_pkg.sv
// Shared types for the symbol-counter game controller.
// Phase encoding plus level and count widths used across the block.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_GEN,
    S_POST,
    S_CHECK,
    S_DONE
  } state_t;

  typedef logic [3:0] level_t;
  typedef logic [7:0] count_t;
  typedef logic [7:0] secs_t;

endpackage

// File: rtl/level_sequencer_tick_gen.sv
// One-second tick prescaler for the game controller.
// Restarts from zero whenever clr is high so each phase gets whole seconds.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic Clk100M,
  input  logic Reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("tick_gen: TICK_DIV must be at least 2");
  end

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/level_sequencer.sv
// Game controller: steps each level through PRE, GEN and POST,
// judges the latched magic-symbol count and advances or ends the game.
module level_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned PRE_SECS     = 3,
  parameter int unsigned GEN_SECS     = 20,
  parameter int unsigned POST_TO_SECS = 10,
  parameter int unsigned TARGET       = 8,
  parameter int unsigned MAX_LEVEL    = 5
) (
  input  logic         Clk100M,
  input  logic         Reset,
  input  logic         startBtn,
  input  logic         levelComplete,
  input  logic [7:0]   magicSymbolCount,
  output logic         preSig,
  output logic         genSig,
  output logic         postSig,
  output logic [3:0]   level,
  output logic [7:0]   secondsLeft,
  output logic         gameOver,
  output logic         gameWon,
  output logic         postTimeout
);

  localparam secs_t  PRE_S = secs_t'(PRE_SECS);
  localparam secs_t  GEN_S = secs_t'(GEN_SECS);
  localparam secs_t  PTO_S = secs_t'(POST_TO_SECS);
  localparam count_t TGT   = count_t'(TARGET);
  localparam level_t MAXL  = level_t'(MAX_LEVEL);

  state_t state_q, state_d;
  logic   btn_q;
  logic   start;
  logic   tick;
  logic   clr;
  logic   pass;
  logic   wd_end;
  secs_t  secs_q;
  secs_t  wdog_q;
  count_t cnt_latch_q;
  level_t level_q;
  logic   pre_q, gen_q, post_q;
  logic   over_q, won_q, pto_q;

  assign start  = startBtn & ~btn_q;
  assign pass   = (cnt_latch_q >= TGT);
  assign wd_end = tick && (wdog_q == 8'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_PRE;
      S_PRE:   if (tick && secs_q == 8'd1) state_d = S_GEN;
      S_GEN:   if (tick && secs_q == 8'd1) state_d = S_POST;
      S_POST:  if (levelComplete || wd_end) state_d = S_CHECK;
      S_CHECK: state_d = (pass && level_q < MAXL) ? S_PRE : S_DONE;
      S_DONE:  if (start) state_d = S_PRE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every phase change restarts the prescaler and second counters.
  assign clr = (state_d != state_q);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .Clk100M (Clk100M),
    .Reset   (Reset),
    .clr     (clr),
    .tick    (tick)
  );

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      btn_q       <= 1'b1;
      secs_q      <= '0;
      wdog_q      <= '0;
      cnt_latch_q <= '0;
      level_q     <= '0;
      pre_q       <= 1'b0;
      gen_q       <= 1'b0;
      post_q      <= 1'b0;
      over_q      <= 1'b0;
      won_q       <= 1'b0;
      pto_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= startBtn;
      pre_q   <= (state_d == S_PRE);
      gen_q   <= (state_d == S_GEN);
      post_q  <= (state_d == S_POST) && (state_q != S_POST);
      over_q  <= (state_d == S_DONE);

      if (clr) begin
        secs_q <= (state_d == S_PRE) ? PRE_S :
                  (state_d == S_GEN) ? GEN_S : '0;
        wdog_q <= (state_d == S_POST) ? PTO_S : '0;
      end else if (tick) begin
        if (secs_q != '0) secs_q <= secs_q - 1'b1;
        if (wdog_q != '0) wdog_q <= wdog_q - 1'b1;
      end

      // levelComplete beats a coincident watchdog tick.
      if (state_q == S_POST && state_d == S_CHECK) begin
        cnt_latch_q <= magicSymbolCount;
        if (!levelComplete) pto_q <= 1'b1;
      end

      if (state_q == S_CHECK) begin
        if (state_d == S_PRE) level_q <= level_q + 1'b1;
        else                  won_q   <= pass;
      end

      if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
        level_q <= level_t'(1);
        won_q   <= 1'b0;
        pto_q   <= 1'b0;
      end
    end
  end

  assign preSig      = pre_q;
  assign genSig      = gen_q;
  assign postSig     = post_q;
  assign level       = level_q;
  assign secondsLeft = secs_q;
  assign gameOver    = over_q;
  assign gameWon     = won_q;
  assign postTimeout = pto_q;

endmodule
